accel_job_sequencer: RTL and testbench

- Autonomous controller for the MNIST accelerator; replaces CPU-driven word-by-word image loading and ready polling.
- On a start command: fetches an image block (pixels plus bias word) from a word-addressed source memory and writes it into the accelerator image buffer. It then pulses the accelerator reset, waits for the accelerator to complete, and reduces the 10 class scores to an argmax.
- Sits between the AXI peripheral decode (start/status registers) and the accelerator plus its image buffer.

---
 rtl/accel_job_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_accel_job_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_job_sequencer.sv
// Job sequencer for the MNIST accelerator: copies one image block from source memory
// into the image buffer, pulses the accelerator reset, waits for completion, then argmaxes the scores.
module accel_job_sequencer #(
    parameter int NUM_WORDS   = 785,
    parameter int RST_CYCLES  = 4,
    parameter int TIMEOUT     = 1000000,
    parameter int NUM_CLASSES = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               src_base,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [3:0]                class_idx,
    output logic [31:0]               max_score,
    output logic                      rd_req,
    output logic [31:0]               rd_addr,
    input  logic                      rd_ack,
    input  logic [31:0]               rd_data,
    output logic                      img_we,
    output logic [9:0]                img_idx,
    output logic [31:0]               img_wdata,
    output logic                      accel_reset,
    input  logic                      accel_ready,
    input  logic [32*NUM_CLASSES-1:0] accel_results
);

    typedef enum logic [2:0] {IDLE, FETCH, WRITE, ARST, RUN, ARGMAX, FIN} state_t;

    localparam logic [9:0]  LAST_WORD  = 10'(NUM_WORDS - 1);
    localparam logic [31:0] LAST_RST   = 32'(RST_CYCLES - 1);
    localparam logic [31:0] LAST_RUN   = 32'(TIMEOUT - 1);
    localparam logic [3:0]  LAST_CLASS = 4'(NUM_CLASSES - 1);

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [9:0]  n_q, n_d;
    logic [31:0] word_q, word_d;
    logic [31:0] cnt_q, cnt_d;
    logic        low_seen_q, low_seen_d;
    logic [3:0]  arg_k_q, arg_k_d;
    logic [3:0]  best_idx_q, best_idx_d;
    logic [31:0] best_q, best_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [3:0]  class_idx_q, class_idx_d;
    logic [31:0] max_score_q, max_score_d;
    logic        accel_reset_q, accel_reset_d;

    logic [31:0] cand;
    logic        cand_wins;
    logic [3:0]  win_idx;
    logic [31:0] win_score;

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        n_d           = n_q;
        word_d        = word_q;
        cnt_d         = cnt_q;
        low_seen_d    = low_seen_q;
        arg_k_d       = arg_k_q;
        best_idx_d    = best_idx_q;
        best_d        = best_q;
        busy_d        = busy_q;
        done_d        = done_q;
        error_d       = error_q;
        class_idx_d   = class_idx_q;
        max_score_d   = max_score_q;
        accel_reset_d = accel_reset_q;

        cand = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (arg_k_q == 4'(i)) cand = accel_results[32*i +: 32];
        end
        // Strictly-greater keeps the lowest index on ties; class 0 always seeds the max.
        cand_wins = (arg_k_q == 4'd0) || ($signed(cand) > $signed(best_q));
        win_idx   = cand_wins ? arg_k_q : best_idx_q;
        win_score = cand_wins ? cand : best_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = src_base;
                    n_d     = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            // rd_req is held with a stable rd_addr until rd_ack; rd_data is valid in the ack cycle.
            FETCH: begin
                if (rd_ack) begin
                    word_d  = rd_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (n_q == LAST_WORD) begin
                    cnt_d         = '0;
                    accel_reset_d = 1'b1;
                    state_d       = ARST;
                end else begin
                    n_d     = n_q + 10'd1;
                    state_d = FETCH;
                end
            end
            ARST: begin
                if (cnt_q == LAST_RST) begin
                    cnt_d         = '0;
                    low_seen_d    = 1'b0;
                    accel_reset_d = 1'b0;
                    state_d       = RUN;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RUN: begin
                // A ready that was already high when RUN began is stale until seen low once.
                if (low_seen_q && accel_ready) begin
                    arg_k_d = '0;
                    state_d = ARGMAX;
                end else if (cnt_q == LAST_RUN) begin
                    error_d     = 1'b1;
                    class_idx_d = 4'hF;
                    max_score_d = '0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = FIN;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (!accel_ready) low_seen_d = 1'b1;
                end
            end
            ARGMAX: begin
                best_idx_d = win_idx;
                best_d     = win_score;
                if (arg_k_q == LAST_CLASS) begin
                    class_idx_d = win_idx;
                    max_score_d = win_score;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = FIN;
                end else begin
                    arg_k_d = arg_k_q + 4'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            base_q        <= '0;
            n_q           <= '0;
            word_q        <= '0;
            cnt_q         <= '0;
            low_seen_q    <= 1'b0;
            arg_k_q       <= '0;
            best_idx_q    <= '0;
            best_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            class_idx_q   <= '0;
            max_score_q   <= '0;
            accel_reset_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            n_q           <= n_d;
            word_q        <= word_d;
            cnt_q         <= cnt_d;
            low_seen_q    <= low_seen_d;
            arg_k_q       <= arg_k_d;
            best_idx_q    <= best_idx_d;
            best_q        <= best_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            class_idx_q   <= class_idx_d;
            max_score_q   <= max_score_d;
            accel_reset_q <= accel_reset_d;
        end
    end

    assign rd_req      = (state_q == FETCH);
    assign rd_addr     = rd_req ? (base_q + {20'd0, n_q, 2'b00}) : 32'd0;
    assign img_we      = (state_q == WRITE);
    assign img_idx     = n_q;
    assign img_wdata   = word_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign class_idx   = class_idx_q;
    assign max_score   = max_score_q;
    assign accel_reset = accel_reset_q;

endmodule

// File: tb/tb_accel_job_sequencer.sv
// Bench for accel_job_sequencer: source-memory and accelerator models, write scoreboard,
// job table plus random jobs, and hand sequences for ignored starts and mid-transfer reset.
module tb_accel_job_sequencer;

    localparam int NUM_WORDS   = 785;
    localparam int RST_CYCLES  = 4;
    localparam int TIMEOUT     = 100;
    localparam int NUM_CLASSES = 10;
    localparam int JOB_BUDGET  = 20000;

    typedef logic [NUM_CLASSES-1:0][31:0] scores_t;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] key;
        int          ack_delay;   // negative: random 0..2 per read
        int          rdy_delay;
        bit          stuck;
        scores_t     scores;
        bit          exp_err;
        logic [3:0]  exp_idx;
        logic [31:0] exp_max;
    } job_vec_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      start;
    logic [31:0]               src_base;
    logic                      busy, done, error;
    logic [3:0]                class_idx;
    logic [31:0]               max_score;
    logic                      rd_req;
    logic [31:0]               rd_addr;
    logic                      rd_ack = 1'b0;
    logic [31:0]               rd_data = 32'hDEAD_BEEF;
    logic                      img_we;
    logic [9:0]                img_idx;
    logic [31:0]               img_wdata;
    logic                      accel_reset;
    logic                      accel_ready = 1'b0;
    logic [32*NUM_CLASSES-1:0] accel_results;

    accel_job_sequencer #(
        .NUM_WORDS  (NUM_WORDS),
        .RST_CYCLES (RST_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .NUM_CLASSES(NUM_CLASSES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_base     (src_base),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .class_idx    (class_idx),
        .max_score    (max_score),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_ack       (rd_ack),
        .rd_data      (rd_data),
        .img_we       (img_we),
        .img_idx      (img_idx),
        .img_wdata    (img_wdata),
        .accel_reset  (accel_reset),
        .accel_ready  (accel_ready),
        .accel_results(accel_results)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Model state for the current job
    logic [31:0] cur_base = '0;
    logic [31:0] cur_key = '0;
    int          cur_ack_delay = 0;
    int          delay_sum = 0;
    int          acc_delay = 50;
    bit          acc_stuck = 1'b0;
    logic [3:0]  prev_idx = '0;

    // Scoreboard / monitor state
    logic [41:0] exp_q[$];
    bit          mon_active = 1'b0;
    bit          xfer_on = 1'b0;
    bit          after_write = 1'b0;
    bit          prev_req = 1'b0;
    logic [31:0] prev_addr = '0;
    int          wr_cnt = 0;
    int          xfer_cycles = 0;
    int          arst_cycles = 0;
    int          post_cycles = 0;
    int          wait_cnt = 0;
    int          this_delay = 0;
    bit          have_delay = 1'b0;

    // Source memory: word at (addr - base)/4 holds that index XOR key.
    always @(negedge clk) begin
        logic [41:0] e;
        if (rd_req !== 1'b1) begin
            rd_ack     = 1'b0;
            rd_data    = 32'hDEAD_BEEF;
            wait_cnt   = 0;
            have_delay = 1'b0;
        end else begin
            if (!have_delay) begin
                this_delay = (cur_ack_delay < 0) ? int'($urandom_range(0, 2)) : cur_ack_delay;
                delay_sum += this_delay;
                have_delay = 1'b1;
            end
            if (wait_cnt == this_delay) begin
                rd_ack  = 1'b1;
                rd_data = ((rd_addr - cur_base) >> 2) ^ cur_key;
            end else begin
                rd_ack  = 1'b0;
                rd_data = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end

        if (mon_active) begin
            if (busy && xfer_on) xfer_cycles++;
            if (busy && !accel_reset && !xfer_on) post_cycles++;
            if (rd_req) begin
                if (prev_req) check("rd_addr_stable", rd_addr, prev_addr);
                if (rd_ack) check("rd_addr", rd_addr, cur_base + 32'(4 * wr_cnt));
            end
            if (img_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("img_idx", {22'd0, img_idx}, {22'd0, e[41:32]});
                    check("img_wdata", img_wdata, e[31:0]);
                end
                wr_cnt++;
                if (wr_cnt == NUM_WORDS) begin
                    xfer_on     = 1'b0;
                    after_write = 1'b1;
                end
            end else if (after_write && accel_reset) begin
                arst_cycles++;
            end
            prev_req  = rd_req && !rd_ack;
            prev_addr = rd_addr;
        end else begin
            prev_req = 1'b0;
        end
    end

    // Accelerator: ready rises on the rdy_delay-th cycle after reset deasserts, or stuck high.
    int run_cnt = 0;
    always @(negedge clk) begin
        if (acc_stuck) begin
            accel_ready = 1'b1;
        end else if (accel_reset !== 1'b0) begin
            accel_ready = 1'b0;
            run_cnt     = 0;
        end else begin
            run_cnt++;
            if (run_cnt >= acc_delay) accel_ready = 1'b1;
        end
    end

    function automatic scores_t pack_scores(input int s[NUM_CLASSES]);
        scores_t r;
        for (int k = 0; k < NUM_CLASSES; k++) r[k] = s[k];
        return r;
    endfunction

    task automatic ref_argmax(input scores_t s, output logic [3:0] idx, output logic [31:0] mx);
        int best;
        best = int'(s[0]);
        idx  = 4'd0;
        for (int k = 1; k < NUM_CLASSES; k++) begin
            if (int'(s[k]) > best) begin
                best = int'(s[k]);
                idx  = 4'(k);
            end
        end
        mx = 32'(best);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_class_idx"}, {28'd0, class_idx}, 32'd0);
        check({tag, "_max_score"}, max_score, 32'd0);
        check({tag, "_rd_req"}, {31'd0, rd_req}, 32'd0);
        check({tag, "_rd_addr"}, rd_addr, 32'd0);
        check({tag, "_img_we"}, {31'd0, img_we}, 32'd0);
        check({tag, "_img_idx"}, {22'd0, img_idx}, 32'd0);
        check({tag, "_img_wdata"}, img_wdata, 32'd0);
        check({tag, "_accel_reset"}, {31'd0, accel_reset}, 32'd1);
    endtask

    // Drives start in the current cycle; returns at the first busy cycle.
    task automatic start_job(input job_vec_t v);
        cur_base      = v.base;
        cur_key       = v.key;
        cur_ack_delay = v.ack_delay;
        acc_delay     = v.rdy_delay;
        acc_stuck     = v.stuck;
        accel_results = v.scores;
        exp_q.delete();
        for (int k = 0; k < NUM_WORDS; k++) exp_q.push_back({10'(k), 32'(k) ^ v.key});
        wr_cnt      = 0;
        xfer_cycles = 0;
        arst_cycles = 0;
        post_cycles = 0;
        delay_sum   = 0;
        xfer_on     = 1'b1;
        after_write = 1'b0;
        mon_active  = 1'b1;
        src_base    = v.base;
        start       = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        src_base = $urandom;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_cleared", {31'd0, done}, 32'd0);
        check("error_cleared", {31'd0, error}, 32'd0);
        check("class_idx_held", {28'd0, class_idx}, {28'd0, prev_idx});
    endtask

    // Waits for done; returns in the FIN cycle.
    task automatic finish_job(input job_vec_t v);
        int cyc = 0;
        while (done !== 1'b1 && cyc < JOB_BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("done_within_budget", {31'd0, done}, 32'd1);
        if (done === 1'b1) begin
            check("busy_at_fin", {31'd0, busy}, 32'd0);
            check("error", {31'd0, error}, {31'd0, v.exp_err});
            check("class_idx", {28'd0, class_idx}, {28'd0, v.exp_idx});
            check("max_score", max_score, v.exp_max);
            check("write_count", 32'(wr_cnt), 32'(NUM_WORDS));
            check("xfer_cycles", 32'(xfer_cycles), 32'(2 * NUM_WORDS + delay_sum));
            check("arst_cycles", 32'(arst_cycles), 32'(RST_CYCLES));
            check("run_argmax_cycles", 32'(post_cycles),
                  v.stuck ? 32'(TIMEOUT) : 32'(v.rdy_delay + NUM_CLASSES));
            prev_idx = v.exp_idx;
        end else begin
            reset = 1'b1;
            @(negedge clk);
            reset    = 1'b0;
            prev_idx = 4'd0;
        end
        mon_active = 1'b0;
    endtask

    task automatic run_job(input job_vec_t v);
        @(negedge clk);
        start_job(v);
        finish_job(v);
    endtask

    job_vec_t vecs[5];
    job_vec_t v;
    int       sc[NUM_CLASSES];

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        src_base      = '0;
        accel_results = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("idle");

        vecs[0] = '0;
        vecs[0].base = 32'h3000_0000; vecs[0].ack_delay = 0; vecs[0].rdy_delay = 50;
        sc = '{-5, 3, 9, 9, -100, 0, 2, 8, 1, 7};
        vecs[0].scores = pack_scores(sc);
        vecs[0].exp_idx = 4'd2; vecs[0].exp_max = 32'd9;

        vecs[1] = '0;
        vecs[1].base = 32'h1000_0004; vecs[1].key = 32'hA5A5_0F0F;
        vecs[1].ack_delay = 3; vecs[1].rdy_delay = 20;
        sc = '{-7, -7, -7, -7, -7, -7, -7, -7, -7, -7};
        vecs[1].scores = pack_scores(sc);
        vecs[1].exp_idx = 4'd0; vecs[1].exp_max = 32'hFFFF_FFF9;

        vecs[2] = '0;
        vecs[2].base = 32'hFFFF_FF00; vecs[2].ack_delay = 1; vecs[2].rdy_delay = 30;
        sc = '{int'(32'h8000_0000), 5, -1, 0, 100, 2147483646, 7, 7, 0, 2147483647};
        vecs[2].scores = pack_scores(sc);
        vecs[2].exp_idx = 4'd9; vecs[2].exp_max = 32'h7FFF_FFFF;

        vecs[3] = '0;
        vecs[3].base = 32'h2000_0000; vecs[3].key = 32'hFFFF_FFFF;
        vecs[3].ack_delay = 0; vecs[3].rdy_delay = 10; vecs[3].stuck = 1'b1;
        sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        vecs[3].scores = pack_scores(sc);
        vecs[3].exp_err = 1'b1; vecs[3].exp_idx = 4'hF; vecs[3].exp_max = 32'd0;

        vecs[4] = '0;
        vecs[4].base = 32'h4000_0000; vecs[4].key = 32'h1234_5678;
        vecs[4].ack_delay = 2; vecs[4].rdy_delay = 2;
        sc = '{-10, -9, -8, -7, -1, -1, -20, -30, -2, -3};
        vecs[4].scores = pack_scores(sc);
        vecs[4].exp_idx = 4'd4; vecs[4].exp_max = 32'hFFFF_FFFF;

        for (int i = 0; i < 5; i++) run_job(vecs[i]);

        // start pulsed in FETCH and in FIN is ignored; start in the following IDLE is accepted
        @(negedge clk);
        start_job(vecs[0]);
        for (int c = 0; c < 10 && rd_req !== 1'b1; c++) @(negedge clk);
        check("in_fetch", {31'd0, rd_req}, 32'd1);
        start    = 1'b1;
        src_base = 32'h1234_0000;
        @(negedge clk);
        start = 1'b0;
        check("fetch_start_ignored", {31'd0, busy}, 32'd1);
        finish_job(vecs[0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fin_start_ignored_busy", {31'd0, busy}, 32'd0);
        check("fin_start_ignored_done", {31'd0, done}, 32'd1);
        start_job(vecs[4]);
        finish_job(vecs[4]);

        // reset in the middle of word 400 aborts to reset values
        @(negedge clk);
        start_job(vecs[1]);
        for (int c = 0; c < 3000 && !(img_we === 1'b1 && img_idx == 10'd400); c++) @(negedge clk);
        check("reached_word_400", {22'd0, img_idx}, 32'd400);
        reset      = 1'b1;
        mon_active = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_reset");
        reset    = 1'b0;
        prev_idx = 4'd0;
        v        = vecs[0];
        v.key    = 32'h0BAD_F00D;
        run_job(v);

        for (int r = 0; r < 3; r++) begin
            v           = '0;
            v.base      = $urandom & 32'hFFFF_FFFC;
            v.key       = $urandom;
            v.ack_delay = -1;
            v.rdy_delay = int'($urandom_range(2, 60));
            for (int k = 0; k < NUM_CLASSES; k++) v.scores[k] = 32'($urandom_range(0, 15)) - 32'd8;
            ref_argmax(v.scores, v.exp_idx, v.exp_max);
            run_job(v);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
